// File: rtl/apb_uart_bridge_if.sv
// APB3 bus bundle between an APB master and the UART bridge.
// Signal names follow the APB3 naming so waveforms read naturally.
interface apb_uart_bridge_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_uart_bridge.sv
// APB3 slave front-end: turns APB transfers into one-hot UART core
// requests, holds them until core ready or timeout, rejects bad accesses.
module apb_uart_bridge #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] TX_ADDR = 'h4,
  parameter logic [ADDR_WIDTH-1:0] RX_ADDR = 'h5,
  parameter logic [ADDR_WIDTH-1:0] CFG_LO  = 'h0,
  parameter logic [ADDR_WIDTH-1:0] CFG_HI  = 'h3,
  parameter int TIMEOUT = 1048575
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  apb_uart_bridge_if.slave      apb,
  output logic [DATA_WIDTH-1:0] write_data_in,
  output logic [ADDR_WIDTH-1:0] config_address,
  output logic                  TX_detect,
  output logic                  RX_detect,
  output logic                  config_write_detect,
  output logic                  config_read_detect,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic                  ready,
  input  logic                  error
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;
  typedef enum logic [1:0] {K_TX, K_RX, K_CW, K_CR} kind_t;

  state_t state, state_nx;
  kind_t  kind, kind_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_nx;
  logic err_q, err_nx;
  logic setup, done;
  logic in_cfg;
  logic [ADDR_WIDTH-1:0] cfg_off;

  // Offset form keeps the range test free of a constant >= 0 compare.
  assign cfg_off = apb.PADDR - CFG_LO;
  assign in_cfg  = cfg_off <= (CFG_HI - CFG_LO);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state          <= IDLE;
      kind           <= K_TX;
      cnt            <= '0;
      rdata_q        <= '0;
      err_q          <= 1'b0;
      config_address <= '0;
      write_data_in  <= '0;
    end else begin
      state <= state_nx;
      kind  <= kind_nx;
      cnt   <= cnt_nx;
      if (setup) begin
        config_address <= apb.PADDR;
        write_data_in  <= apb.PWDATA;
      end
      if (done) begin
        rdata_q <= rdata_nx;
        err_q   <= err_nx;
      end
    end
  end

  always_comb begin
    state_nx            = state;
    kind_nx             = kind;
    cnt_nx              = cnt;
    setup               = 1'b0;
    done                = 1'b0;
    rdata_nx            = '0;
    err_nx              = 1'b0;
    TX_detect           = 1'b0;
    RX_detect           = 1'b0;
    config_write_detect = 1'b0;
    config_read_detect  = 1'b0;
    apb.PREADY          = 1'b0;
    apb.PSLVERR         = 1'b0;
    apb.PRDATA          = '0;
    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (apb.PSEL && !apb.PENABLE) begin
          setup    = 1'b1;
          state_nx = ACCESS;
          if (apb.PWRITE && apb.PADDR == TX_ADDR)
            kind_nx = K_TX;
          else if (!apb.PWRITE && apb.PADDR == RX_ADDR)
            kind_nx = K_RX;
          else if (in_cfg)
            kind_nx = apb.PWRITE ? K_CW : K_CR;
          else
            state_nx = ERR;
        end
      end
      ACCESS: begin
        unique case (kind)
          K_TX: TX_detect           = 1'b1;
          K_RX: RX_detect           = 1'b1;
          K_CW: config_write_detect = 1'b1;
          K_CR: config_read_detect  = 1'b1;
        endcase
        cnt_nx = (cnt == '1) ? cnt : cnt + 1'b1;
        if (!apb.PSEL) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (ready) begin
          done     = 1'b1;
          rdata_nx = (kind == K_RX || kind == K_CR) ? read_data : '0;
          err_nx   = error;
          state_nx = RESP;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          done     = 1'b1;
          err_nx   = 1'b1;
          state_nx = RESP;
        end
      end
      RESP: begin
        apb.PREADY  = 1'b1;
        apb.PRDATA  = rdata_q;
        apb.PSLVERR = err_q;
        cnt_nx      = '0;
        state_nx    = IDLE;
      end
      ERR: begin
        apb.PREADY  = 1'b1;
        apb.PSLVERR = 1'b1;
        state_nx    = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_apb_uart_bridge.sv
// Directed bench for apb_uart_bridge: transfers, rejects, timeout,
// abort and asynchronous reset, with hand-computed expectations.
module tb_apb_uart_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        psel = 0, penable = 0, pwrite = 0;
  logic [7:0]  paddr = 0;
  logic [31:0] pwdata = 0;
  logic [31:0] read_data = 0;
  logic        ready = 0, error = 0;

  apb_uart_bridge_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();
  apb_uart_bridge_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus_t ();

  assign bus.PSEL      = psel;
  assign bus.PENABLE   = penable;
  assign bus.PWRITE    = pwrite;
  assign bus.PADDR     = paddr;
  assign bus.PWDATA    = pwdata;
  assign bus_t.PSEL    = psel;
  assign bus_t.PENABLE = penable;
  assign bus_t.PWRITE  = pwrite;
  assign bus_t.PADDR   = paddr;
  assign bus_t.PWDATA  = pwdata;

  logic [31:0] wdi, t_wdi;
  logic [7:0]  cad, t_cad;
  logic tx, rx, cw, cr;
  logic t_tx, t_rx, t_cw, t_cr;

  apb_uart_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .PCLK(clk), .PRESET(rst), .apb(bus),
    .write_data_in(wdi), .config_address(cad),
    .TX_detect(tx), .RX_detect(rx),
    .config_write_detect(cw), .config_read_detect(cr),
    .read_data(read_data), .ready(ready), .error(error)
  );

  apb_uart_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT(16)) dut_t (
    .PCLK(clk), .PRESET(rst), .apb(bus_t),
    .write_data_in(t_wdi), .config_address(t_cad),
    .TX_detect(t_tx), .RX_detect(t_rx),
    .config_write_detect(t_cw), .config_read_detect(t_cr),
    .read_data(32'h0), .ready(1'b0), .error(1'b0)
  );

  int n_chk = 0, n_fail = 0;
  int lat, n_tx, n_rx, n_cw, n_cr, n_multi;
  logic got;
  logic [31:0] rd;
  logic se;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One APB transfer; the core answers after dly ACCESS cycles.
  // Ends in the PREADY cycle with PSEL already released.
  task automatic xfer(input logic w, input logic [7:0] a,
                      input logic [31:0] d, input logic [31:0] rdat,
                      input int dly, input logic e);
    int k;
    @(negedge clk);
    psel = 1; penable = 0; pwrite = w; paddr = a; pwdata = d;
    ready = 0; error = 0;
    lat = 1; k = 0; got = 0; rd = 0; se = 0;
    n_tx = 0; n_rx = 0; n_cw = 0; n_cr = 0; n_multi = 0;
    while (!got && lat < 2000) begin
      @(negedge clk);
      penable = 1;
      lat++;
      n_tx += int'(tx); n_rx += int'(rx);
      n_cw += int'(cw); n_cr += int'(cr);
      if (int'(tx) + int'(rx) + int'(cw) + int'(cr) > 1) n_multi++;
      if (bus.PREADY) begin
        got = 1; rd = bus.PRDATA; se = bus.PSLVERR;
        ready = 0; error = 0; psel = 0; penable = 0;
      end else begin
        ready = (k == dly);
        error = e && (k == dly);
        read_data = rdat;
        k++;
      end
    end
    chk("xfer_bound", 32'(got), 1);
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk);
    chk({tag, "_pready"}, 32'(bus.PREADY), 0);
    chk({tag, "_prdata"}, bus.PRDATA, 0);
    chk({tag, "_pslverr"}, 32'(bus.PSLVERR), 0);
  endtask

  logic [7:0] bad_a [3] = '{8'h5, 8'h4, 8'h9};
  logic       bad_w [3] = '{1'b1, 1'b0, 1'b1};

  initial begin
    int npr;
    repeat (3) @(negedge clk);
    chk("rst_pready", 32'(bus.PREADY), 0);
    chk("rst_strobes", {tx, rx, cw, cr}, 0);
    chk("rst_cad", 32'(cad), 0);
    chk("rst_wdi", wdi, 0);
    rst = 0;
    idle_chk("post_rst");

    xfer(1, 8'h0, 32'd115200, 0, 1, 0);
    chk("cw_cycles", n_cw, 2);
    chk("cw_other", n_tx + n_rx + n_cr, 0);
    chk("cw_lat", lat, 4);
    chk("cw_slverr", 32'(se), 0);
    chk("cw_cad", 32'(cad), 0);
    chk("cw_wdi", wdi, 32'd115200);
    idle_chk("cw_after");

    xfer(0, 8'h1, 0, 32'd8, 0, 0);
    chk("cr_cycles", n_cr, 1);
    chk("cr_lat", lat, 3);
    chk("cr_prdata", rd, 8);
    chk("cr_slverr", 32'(se), 0);
    idle_chk("cr_after");

    xfer(1, 8'h4, 32'hA5, 32'hFFFF, 500, 0);
    chk("tx_cycles", n_tx, 501);
    chk("tx_lat", lat, 503);
    chk("tx_prdata", rd, 0);
    chk("tx_slverr", 32'(se), 0);
    chk("tx_wdi", wdi, 32'hA5);
    idle_chk("tx_after");

    for (int i = 0; i < 3; i++) begin
      xfer(bad_w[i], bad_a[i], 32'h77, 32'h99, 0, 1);
      chk("bad_lat", lat, 2);
      chk("bad_slverr", 32'(se), 1);
      chk("bad_prdata", rd, 0);
      chk("bad_strobes", n_tx + n_rx + n_cw + n_cr, 0);
      idle_chk("bad_after");
    end

    xfer(1, 8'h3, 32'h2, 0, 2, 1);
    chk("cwerr_cycles", n_cw, 3);
    chk("cwerr_slverr", 32'(se), 1);
    idle_chk("cwerr_after");

    xfer(1, 8'h2, 32'd9600, 0, 0, 0);
    chk("b2b1_lat", lat, 3);
    xfer(0, 8'h3, 0, 32'h1234, 0, 0);
    chk("b2b2_lat", lat, 3);
    chk("b2b2_cr", n_cr, 1);
    chk("b2b2_prdata", rd, 32'h1234);
    chk("onehot", n_multi, 0);
    idle_chk("b2b_after");

    @(negedge clk);
    ready = 1; error = 1; npr = 0;
    repeat (4) begin
      @(negedge clk);
      npr += int'(bus.PREADY) + int'(tx) + int'(rx) + int'(cw) + int'(cr);
    end
    ready = 0; error = 0;
    chk("idle_ready_ignored", npr, 0);

    // Timeout on the short-timeout instance, abort on the main one.
    @(negedge clk);
    psel = 1; penable = 0; pwrite = 0; paddr = 8'h5;
    lat = 1; got = 0; n_rx = 0; rd = 0; se = 0;
    while (!got && lat < 200) begin
      @(negedge clk);
      penable = 1;
      lat++;
      n_rx += int'(t_rx);
      if (bus_t.PREADY) begin
        got = 1; rd = bus_t.PRDATA; se = bus_t.PSLVERR;
      end
    end
    chk("to_bound", 32'(got), 1);
    chk("to_rx_cycles", n_rx, 16);
    chk("to_lat", lat, 18);
    chk("to_slverr", 32'(se), 1);
    chk("to_prdata", rd, 0);
    chk("ab_rx_held", 32'(rx), 1);
    psel = 0; penable = 0;
    @(negedge clk);
    chk("ab_rx_drop", 32'(rx), 0);
    npr = int'(bus.PREADY);
    repeat (3) begin
      @(negedge clk);
      npr += int'(bus.PREADY);
    end
    chk("ab_no_pready", npr, 0);

    @(negedge clk);
    psel = 1; penable = 0; pwrite = 1; paddr = 8'h4; pwdata = 32'h7;
    @(negedge clk);
    penable = 1;
    chk("rst_pre_tx", 32'(tx), 1);
    @(negedge clk);
    rst = 1;
    #1;
    chk("arst_tx", 32'(tx), 0);
    chk("arst_pready", 32'(bus.PREADY), 0);
    chk("arst_pslverr", 32'(bus.PSLVERR), 0);
    chk("arst_wdi", wdi, 0);
    psel = 0; penable = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rel_strobes", {tx, rx, cw, cr}, 0);
    chk("rel_pready", 32'(bus.PREADY), 0);

    xfer(0, 8'h3, 0, 32'h55, 0, 0);
    chk("rel_cr_lat", lat, 3);
    chk("rel_cr_prdata", rd, 32'h55);
    idle_chk("final");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
